sub32_seq: RTL and testbench



---
 rtl/sub32_pkg.sv | 13 +
 rtl/sub32_seq_cla8.sv | 37 +++
 rtl/sub32_seq.sv | 109 ++++++++++
 tb/tb_sub32_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub32_pkg.sv
// Shared constants and state encoding for the sequential 32-bit subtractor.
package sub32_pkg;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub32_seq_cla8.sv
// Combinational 8-bit carry-lookahead adder: s = a + b + ci, co = carry out.
// Every carry is expanded directly from generate/propagate terms and ci,
// so no carry depends on another carry.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin
    logic v_cy;
    logic v_pp;
    w_c    = '0;
    w_c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      v_cy = 1'b0;
      v_pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        v_cy = v_cy | (v_pp & w_g[j]);
        v_pp = v_pp & w_p[j];
      end
      w_c[i+1] = v_cy | (v_pp & ci);
    end
  end

  assign s  = w_p ^ w_c[7:0];
  assign co = w_c[8];
endmodule

// File: rtl/sub32_seq.sv
// Sequential 32-bit subtractor: d = a - b - bi computed one 8-bit slice per
// cycle through a single shared cla8 (a + ~b + ~bi). Valid/ready on both sides.
// WIDTH must equal SLICE * NSLICE and SLICE must match the 8-bit cla8.
module sub32_seq
  import sub32_pkg::*;
#(
  parameter int WIDTH = sub32_pkg::WIDTH,
  parameter int SLICE = sub32_pkg::SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_nb;
  logic               r_c;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;
  logic               r_ovalid;

  logic               w_accept;
  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_nb_sl;
  logic [SLICE-1:0]   w_s;
  logic               w_co;
  logic               w_last;

  // i_ready comes from the state register only: no input-to-output path.
  assign i_ready  = (r_state == ST_IDLE);
  assign w_accept = i_ready & i_valid;
  assign w_last   = (r_cnt == CNT_W'(NSLICE - 1));

  // Slice mux: select the operand bytes addressed by the slice counter.
  assign w_a_sl  = r_a[int'(r_cnt) * SLICE +: SLICE];
  assign w_nb_sl = r_nb[int'(r_cnt) * SLICE +: SLICE];

  cla8 u_cla8 (
    .a  (w_a_sl),
    .b  (w_nb_sl),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );

  // Operand capture at acceptance; operands need no reset value.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= a;
      r_nb <= ~b;
    end
  end

  // Control FSM with slice counter, carry chain and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_d      <= '0;
      r_bo     <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_c     <= ~bi;
            r_cnt   <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_d[int'(r_cnt) * SLICE +: SLICE] <= w_s;
          r_c   <= w_co;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // A missing carry out of the top slice means a borrow.
            r_bo     <= ~w_co;
            r_ovalid <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            r_ovalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_ovalid <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_valid = r_ovalid;
  assign d       = r_d;
  assign bo      = r_bo;
endmodule

// File: tb/tb_sub32_seq.sv
// Scoreboard bench for sub32_seq: the driver pushes the arithmetic result of
// each accepted request, the monitor pops and compares on each result.
module tb_sub32_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        bi_i;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] d;
  logic        bo;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cycle  = 0;
  logic rnd_ready   = 1'b0;
  logic force_ready = 1'b1;

  sub32_seq dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .a       (a_i),
    .b       (b_i),
    .bi      (bi_i),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .d       (d),
    .bo      (bo)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Consumer: o_ready either random or forced by the main sequence.
  initial begin
    o_ready = 1'b1;
    forever begin
      @(negedge clk);
      o_ready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned subtraction in 33 bits.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic tbi, input int acc);
    exp_t e;
    logic [32:0] diff;
    diff  = {1'b0, ta} - {1'b0, tb} - 33'(tbi);
    e.d   = diff[31:0];
    e.bo  = ({1'b0, ta} < ({1'b0, tb} + 33'(tbi)));
    e.acc = acc;
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tbi);
    int g;
    @(negedge clk);
    a_i = ta; b_i = tb; bi_i = tbi; i_valid = 1'b1;
    g = 0;
    while (!i_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!i_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: i_ready never rose within 200 cycles");
      i_valid = 1'b0;
      return;
    end
    sb.push_back(model(ta, tb, tbi, cycle + 1));
    @(negedge clk);
    // Scramble inputs while the operation is in CALC.
    i_valid = 1'b0;
    a_i = $urandom; b_i = $urandom; bi_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || o_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare on o_valid rising, check stability while held.
  initial begin
    logic        prev_ov = 1'b0;
    logic [31:0] pd      = '0;
    logic        pbo     = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0;
        continue;
      end
      if (o_valid) begin
        check("i_ready_low_in_done", 64'(i_ready), 64'd0);
        if (!prev_ov) begin
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_o_valid: d=0x%0h bo=%0b with no pending request", d, bo);
          end else begin
            e = sb.pop_front();
            check("d", 64'(d), 64'(e.d));
            check("bo", 64'(bo), 64'(e.bo));
            check("latency", 64'(cycle - e.acc), 64'd4);
          end
        end else begin
          check("d_stable", 64'(d), 64'(pd));
          check("bo_stable", 64'(bo), 64'(pbo));
        end
        pd  = d;
        pbo = bo;
      end
      prev_ov = o_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    int n_acc;
    reset = 1'b1; i_valid = 1'b0; a_i = '0; b_i = '0; bi_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_bo", 64'(bo), 64'd0);
    check("rst_i_ready", 64'(i_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    send(32'h5555_5555, 32'h3333_3333, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    send(32'h8888_8888, 32'h7777_7777, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    send(32'h0000_0005, 32'h0000_0005, 1'b0);
    drain();

    // Backpressure: consumer stalls three cycles in DONE.
    force_ready = 1'b0;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    begin
      int g = 0;
      while (!o_valid && g < 50) begin
        @(negedge clk);
        g++;
      end
    end
    check("bp_o_valid_seen", 64'(o_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("bp_still_valid", 64'(o_valid), 64'd1);
    force_ready = 1'b1;
    drain();

    // Reset after E2 of an operation discards the partial result.
    send(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check("midrst_o_valid", 64'(o_valid), 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    check("midrst_bo", 64'(bo), 64'd0);
    check("midrst_i_ready", 64'(i_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    send(32'd10, 32'd3, 1'b0);
    drain();

    // Streaming: i_valid held high, acceptances must be 6 cycles apart.
    @(negedge clk);
    a_i = $urandom; b_i = $urandom; bi_i = 1'($urandom_range(0, 1));
    i_valid = 1'b1;
    n_acc = 0;
    last_acc = 0;
    for (int g = 0; g < 200 && n_acc < 5; g++) begin
      if (i_ready) begin
        sb.push_back(model(a_i, b_i, bi_i, cycle + 1));
        if (n_acc > 0) check("stream_spacing", 64'(cycle + 1 - last_acc), 64'd6);
        last_acc = cycle + 1;
        n_acc++;
        @(negedge clk);
        a_i = $urandom; b_i = $urandom; bi_i = 1'($urandom_range(0, 1));
      end else begin
        @(negedge clk);
      end
    end
    check("stream_count", 64'(n_acc), 64'd5);
    i_valid = 1'b0;
    drain();

    // Random phase with random consumer stalls and corner operands.
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: rb = '1;
        2: rb = ra;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
